// File: rtl/load_ext_ctrl_pkg.sv
// Shared load-path definitions: op codes, error codes, FSM states and the
// alignment/legality rule used when a load is accepted.
package load_ext_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LBU = 3'b001,
    OP_LH  = 3'b010,
    OP_LHU = 3'b011,
    OP_LW  = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_ALIGN   = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ERR,
    ST_DONE
  } state_e;

  // High when the op is illegal or the address is not naturally aligned for it.
  function automatic logic load_fault(input logic [2:0] op, input logic [1:0] lo);
    logic f;
    case (op)
      OP_LB, OP_LBU: f = 1'b0;
      OP_LH, OP_LHU: f = lo[0];
      OP_LW:         f = (lo != 2'b00);
      default:       f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/load_ext_ctrl_lane_ext.sv
// Combinational lane select and sign/zero extension of a little-endian
// memory word for byte, halfword and word loads.
module load_lane_ext
  import load_ext_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? word[31:16] : word[15:0];
    ext      = '0;
    case (op)
      OP_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ext = {24'h000000, byte_sel};
      OP_LH:   ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ext = {16'h0000, half_sel};
      OP_LW:   ext = word;
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/load_ext_ctrl.sv
// Single-load sequencer: issues one word read on the request/ack bus, extends
// the addressed lane, and reports misalignment or bus timeout with done.
module load_ext_ctrl
  import load_ext_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] lane_val;

  load_lane_ext u_lane_ext (
    .op   (op_q),
    .addr (addr_q[1:0]),
    .word (mem_rdata),
    .ext  (lane_val)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = load_fault(op, addr[1:0]) ? ST_ERR : ST_REQ;
      ST_REQ:  if (mem_ack || (cnt_q == CNT_LAST)) state_d = ST_DONE;
      ST_ERR:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == ST_REQ) || (state_q == ST_ERR);
    mem_req = (state_q == ST_REQ);
    done    = (state_q == ST_DONE);
  end

  // Ack wins over timeout when both land on the final wait cycle.
  always_comb begin
    op_d    = op_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: if (start) begin
        op_d   = op;
        addr_d = addr;
        cnt_d  = '0;
      end
      ST_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_ack) begin
          rdata_d = lane_val;
          err_d   = ERR_OK;
        end else if (cnt_q == CNT_LAST) begin
          err_d = ERR_TIMEOUT;
        end
      end
      ST_ERR:  err_d = ERR_ALIGN;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      op_q    <= op_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rdata    = rdata_q;
  assign err      = err_q;
  assign mem_addr = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_load_ext_ctrl.sv
// Randomized self-checking bench for load_ext_ctrl against an arithmetic
// reference of lane selection, extension, alignment and timing rules.
module tb_load_ext_ctrl;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] addr = '0;
  logic        busy, done, mem_req;
  logic [31:0] rdata, mem_addr;
  logic [1:0]  err;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [31:0] exp_rdata = '0;
  logic [1:0]  exp_err = 2'b00;

  load_ext_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .addr      (addr),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_legal(input int o, input logic [31:0] a);
    int lo;
    lo = int'(a % 4);
    if (o == 0 || o == 1) return 1'b1;
    if (o == 2 || o == 3) return (lo % 2) == 0;
    if (o == 4) return lo == 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input int o, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (o)
      0: return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      1: return b;
      2: return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      3: return h;
      default: return w;
    endcase
  endfunction

  // delay: cycles after T1 before ack; negative means ack never comes.
  task automatic run_load(input int o, input logic [31:0] a, input logic [31:0] w,
                          input int delay, input bit noise);
    bit legal;
    bit timed_out;
    int k_done;
    legal     = ref_legal(o, a);
    timed_out = legal && (delay < 0 || delay >= int'(TIMEOUT));
    if (!legal)        k_done = 2;
    else if (timed_out) k_done = int'(TIMEOUT) + 1;
    else               k_done = delay + 2;

    @(negedge clk);
    start = 1'b1; op = 3'(o); addr = a; mem_ack = 1'b0;
    for (int k = 1; k <= k_done; k++) begin
      @(negedge clk);
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      op    = 3'($urandom);
      addr  = $urandom;
      if (k < k_done) begin
        check("busy", busy, 1);
        check("done_early", done, 0);
        check("mem_req", mem_req, legal);
        if (legal) check("mem_addr", mem_addr, a - (a % 4));
        mem_ack   = legal && !timed_out && (k == delay + 1);
        mem_rdata = mem_ack ? w : $urandom;
      end else begin
        if (!legal)         exp_err = 2'b01;
        else if (timed_out) exp_err = 2'b10;
        else begin
          exp_err   = 2'b00;
          exp_rdata = ref_load(o, a, w);
        end
        check("done", done, 1);
        check("busy_in_done", busy, 0);
        check("req_in_done", mem_req, 0);
        check("rdata", rdata, exp_rdata);
        check("err", err, exp_err);
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
    @(negedge clk);
    start = 1'b0; mem_ack = 1'b0;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_req", mem_req, 0);
    check("err_hold", err, exp_err);
    check("rdata_hold", rdata, exp_rdata);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", err, 0);
    check("rst_req", mem_req, 0);
    check("rst_maddr", mem_addr, 0);
    rst = 1'b0;

    run_load(1, 32'h1003, 32'h80FF7F01, 0, 1'b0);
    check("dir_lbu", rdata, 32'h00000080);
    run_load(0, 32'h1003, 32'h80FF7F01, 0, 1'b0);
    check("dir_lb", rdata, 32'hFFFFFF80);
    run_load(2, 32'h1002, 32'h80FF7F01, 1, 1'b0);
    check("dir_lh", rdata, 32'hFFFF80FF);
    run_load(3, 32'h1002, 32'h80FF7F01, 0, 1'b0);
    check("dir_lhu", rdata, 32'h000080FF);
    run_load(0, 32'h1000, 32'h80FF7F01, 2, 1'b0);
    check("dir_lb0", rdata, 32'h00000001);
    run_load(4, 32'h1001, 32'h80FF7F01, 0, 1'b1);
    check("dir_lw_mis", err, 2'b01);
    run_load(7, 32'h1000, 32'h80FF7F01, 0, 1'b1);
    check("dir_badop", err, 2'b01);
    run_load(4, 32'h2000, 32'hCAFEBABE, 3, 1'b1);
    check("dir_lw_wait", rdata, 32'hCAFEBABE);
    run_load(4, 32'h3000, 32'h12345678, -1, 1'b1);
    check("dir_timeout", err, 2'b10);
    check("dir_to_keep", rdata, 32'hCAFEBABE);
    run_load(4, 32'h3004, 32'h0BADF00D, int'(TIMEOUT) - 1, 1'b0);
    check("dir_last_ack", err, 2'b00);

    // Reset while REQ is waiting for ack.
    @(negedge clk);
    start = 1'b1; op = 3'b001; addr = 32'h4001;
    @(negedge clk);
    start = 1'b0;
    check("pre_rst_req", mem_req, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_rdata", rdata, 0);
    exp_rdata = '0;
    exp_err   = 2'b00;
    run_load(1, 32'h4001, 32'h11229933, 1, 1'b0);
    check("post_rst_lbu", rdata, 32'h00000099);

    for (int i = 0; i < 150; i++) begin
      int o, d;
      o = int'($urandom_range(0, 7));
      d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
      run_load(o, $urandom, $urandom, d, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
